// File: rtl/bird_pkg.sv
// bird_pkg: shared state codes, colours and render FSM type
// for the bird datapath slice.
package bird_pkg;

  localparam logic [2:0] ST_READY   = 3'b000;
  localparam logic [2:0] ST_START   = 3'b010;
  localparam logic [2:0] ST_RAISING = 3'b110;
  localparam logic [2:0] ST_FALLING = 3'b011;
  localparam logic [2:0] ST_STOP    = 3'b001;
  localparam logic [2:0] ST_DRAW    = 3'b111;

  localparam logic [2:0] BG_COLOUR    = 3'b000;
  localparam logic [2:0] BIRD_COLOUR  = 3'b110;
  localparam logic [2:0] FLASH_COLOUR = 3'b111;

  localparam int VEL_W = 5;

  typedef enum logic [1:0] {
    R_IDLE,
    R_ERASE,
    R_UPDATE,
    R_PAINT
  } render_t;

  function automatic logic is_mode(input logic [2:0] s);
    return (s == ST_READY)   || (s == ST_START) ||
           (s == ST_RAISING) || (s == ST_FALLING) ||
           (s == ST_STOP);
  endfunction

endpackage

// File: rtl/bird_datapath_if.sv
// bird_datapath_if: VGA adapter pixel write bus.
// master drives pixels, slave is the adapter.
interface bird_datapath_if;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;

  modport master (output x, output y, output colour, output plot);
  modport slave  (input x, input y, input colour, input plot);
endinterface

// File: rtl/bird_datapath_sprite_scan.sv
// sprite_scan: row-major pixel counter for one sprite pass.
// Offsets come from the next count so the caller can register them.
module sprite_scan #(
  parameter int SIZE = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_start,
  input  logic                    i_en,
  output logic                    o_done,
  output logic [$clog2(SIZE)-1:0] o_dx,
  output logic [$clog2(SIZE)-1:0] o_dy
);
  localparam int LW = $clog2(SIZE);
  localparam int CW = 2 * LW;

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_nxt;

  always_comb begin
    w_nxt = r_cnt;
    if (i_start)
      w_nxt = '0;
    else if (i_en)
      w_nxt = r_cnt + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_cnt <= '0;
    else
      r_cnt <= w_nxt;
  end

  assign o_done = &r_cnt;
  assign o_dx   = w_nxt[LW-1:0];
  assign o_dy   = w_nxt[CW-1:LW];

endmodule

// File: rtl/bird_datapath.sv
// bird_datapath: bird position/velocity and erase-update-paint render.
// Define BIRD_FLASH_EN to render STOP ticks with a flashing colour.
module bird_datapath
  import bird_pkg::*;
#(
  parameter int X_POS     = 40,
  parameter int Y_START   = 60,
  parameter int BIRD_SIZE = 4,
  parameter int CEIL      = 0,
  parameter int FLOOR     = 110,
  parameter int GRAVITY   = 1,
  parameter int FLAP_VEL  = 3,
  parameter int VMAX      = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [2:0]       state,
  input  logic             frame_tick,
  bird_datapath_if.master  vga,
  output logic [6:0]       bird_y,
  output logic             touched,
  output logic             busy
);
  localparam int LW = $clog2(BIRD_SIZE);
  localparam logic signed [VEL_W:0]   VMAX_W = (VEL_W+1)'(VMAX);
  localparam logic signed [VEL_W:0]   GRAV_W = (VEL_W+1)'(GRAVITY);
  localparam logic signed [VEL_W-1:0] FLAP_W = VEL_W'(-FLAP_VEL);
  localparam logic signed [8:0]       CEIL_W = 9'(CEIL);
  localparam logic signed [8:0]       TOP_W  = 9'(FLOOR - BIRD_SIZE);

  render_t r_st, w_nst;
  logic [2:0] r_mode;
  logic [6:0] r_by, w_by_n;
  logic signed [VEL_W-1:0] r_vel, w_vel_a, w_vel_n;
  logic signed [VEL_W:0] w_vsum;
  logic signed [8:0] w_ny;
  logic r_touched, w_t_n;
  logic [7:0] r_x;
  logic [6:0] r_y;
  logic [2:0] r_col, w_paint_col;
  logic r_plot;
  logic w_go, w_accept, w_done;
  logic [LW-1:0] w_dx, w_dy;

`ifdef BIRD_FLASH_EN
  logic r_tog;
  assign w_go = 1'b1;
  assign w_paint_col = r_tog ? FLASH_COLOUR : BIRD_COLOUR;
`else
  assign w_go = (r_mode != ST_STOP);
  assign w_paint_col = BIRD_COLOUR;
`endif

  assign w_accept = (r_st == R_IDLE) && frame_tick && w_go;

  sprite_scan #(.SIZE(BIRD_SIZE)) u_scan (
    .clk     (clk),
    .rst_n   (resetn),
    .i_start (w_accept),
    .i_en    ((r_st == R_ERASE) || (r_st == R_PAINT)),
    .o_done  (w_done),
    .o_dx    (w_dx),
    .o_dy    (w_dy)
  );

  always_comb begin
    w_nst = r_st;
    case (r_st)
      R_IDLE:   if (w_accept) w_nst = R_ERASE;
      R_ERASE:  if (w_done) w_nst = R_UPDATE;
      R_UPDATE: w_nst = R_PAINT;
      R_PAINT:  if (w_done) w_nst = R_IDLE;
      default:  w_nst = R_IDLE;
    endcase
  end

  always_comb begin
    w_vel_a = r_vel;
    w_vel_n = r_vel;
    w_by_n  = r_by;
    w_t_n   = r_touched;
    w_ny    = '0;
    w_vsum  = {r_vel[VEL_W-1], r_vel} + GRAV_W;
    if (r_st == R_UPDATE) begin
      if (r_mode == ST_READY) begin
        w_by_n  = 7'(Y_START);
        w_vel_n = '0;
        w_t_n   = 1'b0;
      end
`ifdef BIRD_FLASH_EN
      else if (r_mode == ST_STOP) begin
        w_by_n = r_by;
      end
`endif
      else begin
        unique case (1'b1)
          (r_mode == ST_START),
          (r_mode == ST_RAISING):
            w_vel_a = FLAP_W;
          (r_mode == ST_FALLING):
            w_vel_a = (w_vsum > VMAX_W) ?
                      VMAX_W[VEL_W-1:0] : w_vsum[VEL_W-1:0];
          default: w_vel_a = r_vel;
        endcase
        w_vel_n = w_vel_a;
        w_ny = {2'b00, r_by} +
               {{(9-VEL_W){w_vel_a[VEL_W-1]}}, w_vel_a};
        // Ceiling keeps velocity; floor landing kills it.
        if (w_ny <= CEIL_W) begin
          w_by_n = CEIL_W[6:0];
          w_t_n  = 1'b1;
        end else if (w_ny >= TOP_W) begin
          w_by_n  = TOP_W[6:0];
          w_t_n   = 1'b1;
          w_vel_n = '0;
        end else begin
          w_by_n = w_ny[6:0];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_st      <= R_IDLE;
      r_mode    <= ST_READY;
      r_by      <= 7'(Y_START);
      r_vel     <= '0;
      r_touched <= 1'b0;
    end else begin
      r_st      <= w_nst;
      r_by      <= w_by_n;
      r_vel     <= w_vel_n;
      r_touched <= w_t_n;
      if (state != ST_DRAW && is_mode(state))
        r_mode <= state;
    end
  end

`ifdef BIRD_FLASH_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      r_tog <= 1'b0;
    else if (r_st == R_UPDATE && r_mode == ST_READY)
      r_tog <= 1'b0;
    else if (r_st == R_PAINT && w_done && r_mode == ST_STOP)
      r_tog <= ~r_tog;
  end
`endif

  // Pixel bus is registered from next-cycle state and count.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_plot <= 1'b0;
      r_x    <= '0;
      r_y    <= '0;
      r_col  <= '0;
    end else begin
      r_plot <= (w_nst == R_ERASE) || (w_nst == R_PAINT);
      r_x    <= 8'(X_POS) + 8'(w_dx);
      r_y    <= w_by_n + 7'(w_dy);
      r_col  <= (w_nst == R_PAINT) ? w_paint_col : BG_COLOUR;
    end
  end

  assign vga.x      = r_x;
  assign vga.y      = r_y;
  assign vga.colour = r_col;
  assign vga.plot   = r_plot;
  assign bird_y     = r_by;
  assign touched    = r_touched;
  assign busy       = (r_st != R_IDLE);

endmodule

// File: tb/tb_bird_datapath.sv
// tb_bird_datapath: randomized render sequences against a
// behavioural model of bird motion and sprite pixel streams.
module tb_bird_datapath;
  import bird_pkg::*;

`ifdef BIRD_FLASH_EN
  localparam bit FLASH = 1'b1;
`else
  localparam bit FLASH = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       resetn;
  logic [2:0] state;
  logic       frame_tick;
  logic [6:0] bird_y;
  logic       touched;
  logic       busy;

  bird_datapath_if vga();

  bird_datapath dut (
    .clk        (clk),
    .resetn     (resetn),
    .state      (state),
    .frame_tick (frame_tick),
    .vga        (vga),
    .bird_y     (bird_y),
    .touched    (touched),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int m_y, m_v, m_t, m_tog;

  task automatic model_reset();
    m_y = 60; m_v = 0; m_t = 0; m_tog = 0;
  endtask

  task automatic model_update(input logic [2:0] m, output int col);
    int ny;
    col = m_tog ? 7 : 6;
    if (m == ST_READY) begin
      m_y = 60; m_v = 0; m_t = 0; m_tog = 0;
      col = 6;
    end else if (m == ST_STOP && FLASH) begin
      m_tog = 1 - m_tog;
    end else begin
      if (m == ST_START || m == ST_RAISING) m_v = -3;
      else if (m == ST_FALLING) m_v = (m_v + 1 > 4) ? 4 : m_v + 1;
      ny = m_y + m_v;
      if (ny <= 0) begin
        m_y = 0; m_t = 1;
      end else if (ny + 4 >= 110) begin
        m_y = 106; m_t = 1; m_v = 0;
      end else begin
        m_y = ny;
      end
    end
  endtask

  task automatic render(input logic [2:0] m, input bit junk,
                        input string name);
    int oy, n, np, bad, col, ex, ey, ec, bx, by, bc;
    bit go;
    @(negedge clk); state = m;
    @(negedge clk);
    if (junk) begin
      state = 3'b100;
      @(negedge clk);
    end
    state = ST_DRAW;
    frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
    oy = m_y;
    go = (m != ST_STOP) || FLASH;
    col = 0;
    if (go) model_update(m, col);
    n = 0; np = 0; bad = 0; bx = 0; by = 0; bc = 0;
    while (busy && n < 80) begin
      if (vga.plot) begin
        ex = 40 + (np % 4);
        ey = ((np < 16) ? oy : m_y) + ((np % 16) / 4);
        ec = (np < 16) ? 0 : col;
        if (vga.x !== ex[7:0] || vga.y !== ey[6:0] ||
            vga.colour !== ec[2:0]) begin
          if (bad == 0) begin
            bx = vga.x; by = vga.y; bc = vga.colour;
          end
          bad++;
        end
        np++;
      end
      n++;
      @(negedge clk);
    end
    n_tests++;
    if (n !== (go ? 33 : 0)) begin
      n_fail++;
      $display("FAIL %s busy_cycles got %0d want %0d", name, n,
               go ? 33 : 0);
    end
    n_tests++;
    if (np !== (go ? 32 : 0)) begin
      n_fail++;
      $display("FAIL %s plots got %0d want %0d", name, np,
               go ? 32 : 0);
    end
    n_tests++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL %s pixels bad=%0d first got (%0d,%0d,%0d) oy=%0d ny=%0d col=%0d",
               name, bad, bx, by, bc, oy, m_y, col);
    end
    n_tests++;
    if (bird_y !== m_y[6:0] || touched !== m_t[0]) begin
      n_fail++;
      $display("FAIL %s pos got y=%0d t=%0d want y=%0d t=%0d",
               name, bird_y, touched, m_y, m_t);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; state = ST_READY; frame_tick = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    n_tests++;
    if (bird_y !== 7'd60 || touched !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_status got y=%0d t=%0d b=%0d want 60 0 0",
               bird_y, touched, busy);
    end
    n_tests++;
    if (vga.plot !== 1'b0 || vga.x !== 8'd0 || vga.y !== 7'd0 ||
        vga.colour !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_pixel got p=%0d x=%0d y=%0d c=%0d want 0",
               vga.plot, vga.x, vga.y, vga.colour);
    end
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_first_tick();
    render(ST_READY, 1'b0, "ready_tick");
    n_tests++;
    if (bird_y !== 7'd60) begin
      n_fail++;
      $display("FAIL ready_y got %0d want 60", bird_y);
    end
  endtask

  task automatic test_falling();
    int exp_y[5] = '{61, 63, 66, 70, 74};
    for (int i = 0; i < 5; i++) begin
      render(ST_FALLING, i == 2, "falling");
      n_tests++;
      if (bird_y !== exp_y[i][6:0]) begin
        n_fail++;
        $display("FAIL falling_seq[%0d] got %0d want %0d", i, bird_y,
                 exp_y[i]);
      end
    end
  endtask

  task automatic test_ceiling();
    for (int i = 0; i < 30 && m_t == 0; i++)
      render(ST_RAISING, 1'b0, "raising");
    n_tests++;
    if (bird_y !== 7'd0 || touched !== 1'b1) begin
      n_fail++;
      $display("FAIL ceiling got y=%0d t=%0d want 0 1", bird_y, touched);
    end
    render(ST_READY, 1'b0, "recentre");
    n_tests++;
    if (bird_y !== 7'd60 || touched !== 1'b0) begin
      n_fail++;
      $display("FAIL recentre got y=%0d t=%0d want 60 0", bird_y,
               touched);
    end
  endtask

  task automatic test_floor();
    for (int i = 0; i < 30 && m_t == 0; i++)
      render(ST_FALLING, 1'b0, "fall_floor");
    n_tests++;
    if (bird_y !== 7'd106 || touched !== 1'b1) begin
      n_fail++;
      $display("FAIL floor got y=%0d t=%0d want 106 1", bird_y, touched);
    end
    render(ST_FALLING, 1'b0, "floor_again");
    render(ST_READY, 1'b0, "floor_reset");
  endtask

  task automatic test_drop();
    int n, extra, col;
    @(negedge clk); state = ST_FALLING;
    @(negedge clk); state = ST_DRAW; frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
    model_update(ST_FALLING, col);
    n = 0;
    while (busy && n < 80) begin
      frame_tick = (n == 10);
      n++;
      @(negedge clk);
    end
    frame_tick = 1'b0;
    n_tests++;
    if (n !== 33) begin
      n_fail++;
      $display("FAIL drop_busy got %0d want 33", n);
    end
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy || vga.plot) extra++;
      @(negedge clk);
    end
    n_tests++;
    if (extra !== 0 || bird_y !== m_y[6:0]) begin
      n_fail++;
      $display("FAIL drop_second got busy_cycles=%0d y=%0d want 0 %0d",
               extra, bird_y, m_y);
    end
  endtask

  task automatic test_stop();
    render(ST_STOP, 1'b0, "stop1");
    render(ST_STOP, 1'b0, "stop2");
    render(ST_STOP, 1'b1, "stop3");
    render(ST_READY, 1'b0, "stop_ready");
  endtask

  task automatic test_random();
    logic [2:0] modes[5] = '{ST_START, ST_RAISING, ST_FALLING,
                             ST_FALLING, ST_READY};
    for (int i = 0; i < 25; i++)
      render(modes[$urandom_range(4, 0)], 1'($urandom_range(1, 0)),
             "random");
  endtask

  task automatic test_reset_mid();
    int n;
    @(negedge clk); state = ST_FALLING;
    @(negedge clk); state = ST_DRAW; frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
    n = 0;
    while (busy && n < 25) begin
      n++;
      @(negedge clk);
    end
    #2 resetn = 1'b0;
    #1;
    model_reset();
    n_tests++;
    if (vga.plot !== 1'b0 || busy !== 1'b0 || bird_y !== 7'd60 ||
        touched !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid got p=%0d b=%0d y=%0d t=%0d want 0 0 60 0",
               vga.plot, busy, bird_y, touched);
    end
    @(negedge clk); resetn = 1'b1;
    render(ST_FALLING, 1'b0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_first_tick();
    test_falling();
    test_ceiling();
    test_floor();
    test_drop();
    test_stop();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
